// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared FSM states, rounding constants and counter sizing for LWE decryption
package decrypt_pkg;
  typedef enum logic [1:0] {S_ACC, S_ROUND, S_OUT} state_t;
  localparam int DEF_N = 30;
  localparam int DEF_P = 6;
  localparam int SHIFT = DEF_N - DEF_P;
  localparam longint unsigned ROUND_HALF = 64'd1 << (SHIFT - 1);
  function automatic int cnt_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/decrypt_vec_mod_round.sv
// mod_round: rounds an N-bit mod-2^N value to its top P bits with wrap-around
module mod_round #(
  parameter int N = 30,
  parameter int P = 6
) (
  input  logic [N-1:0] x,
  output logic [P-1:0] y
);
  localparam logic [N-1:0] HALF = N'(1) << (N - P - 1);
  logic [N-1:0] s;
  assign s = x + HALF;
  assign y = P'(s >> (N - P));
endmodule

// File: rtl/decrypt_vec.sv
// decrypt_vec: streaming LWE decryption, one (sk, c_bot) pair per beat then round to P bits
module decrypt_vec
  import decrypt_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int N = 30,
  parameter int P = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_ct_top,
  input  logic [N-1:0] in_sk_elem,
  input  logic [N-1:0] in_ct_elem,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_result
);
  localparam int CW = cnt_w(DIMENSION);
  localparam logic [CW-1:0] LAST = CW'(DIMENSION - 1);
  state_t state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [N-1:0] acc_q, acc_d, prod;
  logic [P-1:0] res_q, res_d, rounded;
  mod_round #(.N(N), .P(P)) u_round (.x(acc_q), .y(rounded));
  assign prod = in_sk_elem * in_ct_elem;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    acc_d = acc_q;
    res_d = res_q;
    case (state_q)
      S_ACC: if (in_valid) begin
        acc_d = ((beat_q == '0) ? in_ct_top : acc_q) + prod;
        beat_d = (beat_q == LAST) ? '0 : beat_q + 1'b1;
        state_d = (beat_q == LAST) ? S_ROUND : S_ACC;
      end
      S_ROUND: begin
        res_d = rounded;
        state_d = S_OUT;
      end
      S_OUT: state_d = out_ready ? S_ACC : S_OUT;
      default: state_d = S_ACC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      beat_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
  assign in_ready = state_q == S_ACC;
  assign out_valid = state_q == S_OUT;
  assign out_result = res_q;
endmodule

// File: tb/tb_decrypt_vec.sv
// tb_decrypt_vec: directed N=8 checks plus random DIMENSION=1 N=30 run against a reference model
module tb_decrypt_vec;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_iv = 0, a_ir, a_ov, a_or = 0;
  logic [7:0] a_top = 0, a_sk = 0, a_ct = 0;
  logic [1:0] a_res;
  logic b_iv = 0, b_ir, b_ov, b_or = 0;
  logic [29:0] b_top = 0, b_sk = 0, b_ct = 0;
  logic [5:0] b_res;
  int n_chk = 0, n_fail = 0;
  decrypt_vec #(.DIMENSION(2), .N(8), .P(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_ct_top(a_top),
    .in_sk_elem(a_sk), .in_ct_elem(a_ct), .out_valid(a_ov), .out_ready(a_or), .out_result(a_res));
  decrypt_vec #(.DIMENSION(1), .N(30), .P(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_ct_top(b_top),
    .in_sk_elem(b_sk), .in_ct_elem(b_ct), .out_valid(b_ov), .out_ready(b_or), .out_result(b_res));
  function automatic longint unsigned ref_m(input int n, input int p, input longint unsigned top,
      input longint unsigned s0, input longint unsigned c0, input longint unsigned s1, input longint unsigned c1);
    longint unsigned mask = (64'd1 << n) - 1;
    longint unsigned acc = (top + s0 * c0 + s1 * c1) & mask;
    return ((acc + (64'd1 << (n - p - 1))) & mask) >> (n - p);
  endfunction
  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat_a(input logic [7:0] top, input logic [7:0] sk, input logic [7:0] ct);
    a_top = top;
    a_sk = sk;
    a_ct = ct;
    a_iv = 1;
    for (int k = 0; k < 50 && !a_ir; k++) tick();
    chk("beat_ready", a_ir, 1);
    tick();
    a_iv = 0;
    a_top = 8'hA5;
    a_sk = 8'h5A;
    a_ct = 8'hC3;
  endtask
  task automatic finish_a(input string tag, input longint unsigned exp);
    chk({tag, "_lat_lo"}, a_ov, 0);
    tick();
    chk({tag, "_lat_hi"}, a_ov, 1);
    chk({tag, "_res"}, a_res, exp);
    a_or = 1;
    tick();
    a_or = 0;
    chk({tag, "_released"}, {a_ov, a_ir}, 2'b01);
  endtask
  task automatic decode_a(input string tag, input logic [7:0] top, input logic [7:0] s0,
      input logic [7:0] c0, input logic [7:0] s1, input logic [7:0] c1);
    beat_a(top, s0, c0);
    beat_a(8'h77, s1, c1);
    finish_a(tag, ref_m(8, 2, top, s0, c0, s1, c1));
  endtask
  initial begin
    longint unsigned q[$];
    longint unsigned exp;
    logic acc;
    int sent, got;
    logic [7:0] rs0, rc0, rs1, rc1, rt;
    tick();
    tick();
    chk("rst_a", {a_ir, a_ov, a_res}, 4'b1000);
    chk("rst_b", {b_ir, b_ov, b_res}, 8'b10000000);
    rst = 0;
    decode_a("basic", 8'h40, 8'h01, 8'h10, 8'h02, 8'h08);
    decode_a("negkey", 8'h00, 8'hFF, 8'h10, 8'h00, 8'h00);
    decode_a("edge1F", 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00);
    decode_a("edge20", 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
    decode_a("edgeDF", 8'hDF, 8'h00, 8'h00, 8'h00, 8'h00);
    decode_a("edgeE0", 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      rt = 8'($urandom); rs0 = 8'($urandom); rc0 = 8'($urandom); rs1 = 8'($urandom); rc1 = 8'($urandom);
      decode_a("rand_a", rt, rs0, rc0, rs1, rc1);
    end
    beat_a(8'h30, 8'h03, 8'h11);
    beat_a(8'h00, 8'h07, 8'h05);
    tick();
    exp = ref_m(8, 2, 8'h30, 8'h03, 8'h11, 8'h07, 8'h05);
    a_top = 8'h80; a_sk = 8'h02; a_ct = 8'h21; a_iv = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {a_ov, a_ir}, 2'b10);
      chk("bp_res", a_res, exp);
      tick();
    end
    a_or = 1;
    tick();
    a_or = 0;
    chk("bp_release", {a_ov, a_ir}, 2'b01);
    beat_a(8'h80, 8'h02, 8'h21);
    beat_a(8'h00, 8'h01, 8'h1F);
    finish_a("bp_next", ref_m(8, 2, 8'h80, 8'h02, 8'h21, 8'h01, 8'h1F));
    beat_a(8'h50, 8'h04, 8'h03);
    for (int k = 0; k < 3; k++) begin
      a_iv = 0;
      tick();
    end
    beat_a(8'h00, 8'h09, 8'h02);
    finish_a("bubble", ref_m(8, 2, 8'h50, 8'h04, 8'h03, 8'h09, 8'h02));
    beat_a(8'h60, 8'h01, 8'h01);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst", {a_ir, a_ov, a_res}, 4'b1000);
    decode_a("after_rst", 8'h10, 8'h05, 8'h06, 8'h03, 8'h02);
    sent = 0;
    got = 0;
    b_top = 30'($urandom); b_sk = 30'($urandom); b_ct = 30'($urandom);
    b_iv = 1;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      b_or = 1'($urandom);
      acc = b_iv && b_ir;
      if (acc) q.push_back(ref_m(30, 6, b_top, b_sk, b_ct, 0, 0));
      if (b_ov && b_or) begin
        exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
        chk("rand_b", b_res, exp);
        got++;
      end
      tick();
      if (acc) begin
        sent++;
        b_top = 30'($urandom); b_sk = 30'($urandom); b_ct = 30'($urandom);
        b_iv = sent < 1000;
      end
    end
    chk("rand_b_count", got, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
